spi_tx_sequencer: RTL and testbench

- Shares one single-byte SPI transmitter between NUM_REQ requesters and sequences multi-byte frames onto it.
- Round-robin arbitration, applied at frame granularity. A granted requester keeps the transmitter until its byte flagged last completes.
- Enforces a programmable inter-byte gap and a per-byte completion watchdog.
- Sits between the register/command clients and the SPI transmitter's wr_en / tx_wr_data / wr_done interface.

---
 rtl/spi_tx_sequencer.sv | 141 ++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sequencer.sv
// rtl/spi_tx_sequencer.sv - frame-granular round-robin sequencer in front of a single-byte SPI transmitter
module spi_tx_sequencer #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_wr_en,
    output logic [7:0]             tx_wr_data,
    input  logic                   tx_wr_done,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_timeout
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_t;

    state_t           state;
    logic [2:0]       rr_ptr;
    logic             last_r;
    logic             locked;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // Requester vectors widened to the 8-requester maximum so a 3-bit index always selects in range
    logic [7:0]  valid_pad;
    logic [7:0]  last_pad;
    logic [63:0] data_pad;

    assign valid_pad = 8'(req_valid);
    assign last_pad  = 8'(req_last);
    assign data_pad  = 64'(req_data);

    // Launch must fall in the very cycle tx_wr_done arrives or the transmitter would relaunch
    assign tx_wr_en = (state == SEND) && !tx_wr_done;
    assign busy     = (state != IDLE);

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [3:0] arb_sum;
    logic [2:0] arb_idx;

    // Round-robin search: first pending requester at or above rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        arb_sum    = 4'd0;
        arb_idx    = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, rr_ptr} + 4'(i);
            arb_idx = 3'((arb_sum >= 4'(NUM_REQ)) ? (arb_sum - 4'(NUM_REQ)) : arb_sum);
            if (!pick_found && valid_pad[arb_idx]) begin
                pick_found = 1'b1;
                pick_idx   = arb_idx;
            end
        end
    end

    logic       sel_ok;
    logic [2:0] sel_idx;
    logic [2:0] rr_next;

    // While a frame is locked only the owner may be accepted; otherwise take the arbitration winner
    always_comb begin
        sel_idx = (state == HOLD) ? grant_id : pick_idx;
        sel_ok  = (state == HOLD) ? valid_pad[grant_id] : pick_found;
        rr_next = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : (grant_id + 3'd1);
    end

    // Sequencer FSM with registered grant, data and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 3'd0;
            grant_id    <= 3'd0;
            tx_wr_data  <= 8'd0;
            req_ready   <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            last_r      <= 1'b0;
            locked      <= 1'b0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            req_ready   <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (sel_ok) begin
                        grant_id   <= sel_idx;
                        tx_wr_data <= data_pad[{sel_idx, 3'b000} +: 8];
                        last_r     <= last_pad[sel_idx];
                        req_ready  <= NUM_REQ'(1) << sel_idx;
                        wd_cnt     <= '0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_wr_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                        if (last_r) begin
                            frame_done <= 1'b1;
                            rr_ptr     <= rr_next;
                            locked     <= 1'b0;
                        end else begin
                            locked     <= 1'b1;
                        end
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        rr_ptr      <= rr_next;
                        locked      <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= locked ? HOLD : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb/tb_spi_tx_sequencer.sv - self-checking bench for spi_tx_sequencer
module tb_spi_tx_sequencer;

    localparam int NUM_REQ    = 4;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_last  = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_wr_en;
    logic [7:0]           tx_wr_data;
    logic                 tx_wr_done = 1'b0;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 frame_done;
    logic                 err_timeout;

    int checks = 0;
    int errors = 0;
    int exp_rr = 0;

    always #5 clk = ~clk;

    spi_tx_sequencer #(
        .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_wr_done(tx_wr_done),
        .grant_id(grant_id), .busy(busy),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (req_ready == '0 && cyc < 60);
    endtask

    task automatic wait_idle(output bit ok);
        int cyc;
        cyc = 0;
        while (busy && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        ok = !busy;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_wr_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = '1; req_last = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, tx_wr_en, grant_id, tx_wr_data, req_ready, frame_done, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b en=%b gid=%0d data=%h rdy=%b fd=%b to=%b expected all 0",
                     busy, tx_wr_en, grant_id, tx_wr_data, req_ready, frame_done, err_timeout);
        end
        req_valid = '0; req_data = '0; req_last = '0;
        rst = 1'b0;
        exp_rr = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_idle busy=%b rdy=%b expected 0/0", busy, req_ready);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || grant_id !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept rdy=%b gid=%0d busy=%b expected 0001/0/1", req_ready, grant_id, busy);
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tx_wr_en !== 1'b1 || tx_wr_data !== 8'hA5) begin
                errors++;
                $display("FAIL single_launch cyc=%0d en=%b data=%h expected 1/a5", k, tx_wr_en, tx_wr_data);
            end
            @(negedge clk);
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL single_ready_pulse rdy=%b expected 0000", req_ready);
            end
        end
        tx_wr_done = 1'b1;
        #1;
        checks++;
        if (tx_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_en_drop en=%b expected 0", tx_wr_en);
        end
        @(negedge clk);
        tx_wr_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_frame_done fd=%b busy=%b expected 1/1", frame_done, busy);
        end
        for (int k = 1; k <= GAP_CYCLES; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k < GAP_CYCLES) || frame_done !== 1'b0 || tx_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL single_gap k=%0d busy=%b fd=%b en=%b expected %b/0/0",
                         k, busy, frame_done, tx_wr_en, k < GAP_CYCLES);
            end
        end
        exp_rr = 1;
        wait_idle(ok);
    endtask

    task automatic test_locked_frame();
        logic [7:0] bytes [3];
        int cyc;
        bit ok;
        bytes = '{8'h11, 8'h22, 8'h33};
        req_valid = 4'b0101; req_data = '0; req_data[7:0] = 8'h44; req_last = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            req_data[23:16] = bytes[b];
            req_last[2] = (b == 2);
            wait_ready(cyc);
            checks++;
            if (req_ready !== 4'b0100 || grant_id !== 3'd2) begin
                errors++;
                $display("FAIL lock_grant byte=%0d rdy=%b gid=%0d expected 0100/2", b, req_ready, grant_id);
            end
            if (b > 0) begin
                checks++;
                if (cyc - 1 < GAP_CYCLES) begin
                    errors++;
                    $display("FAIL lock_gap byte=%0d idle=%0d expected >=%0d", b, cyc - 1, GAP_CYCLES);
                end
            end
            checks++;
            if (tx_wr_en !== 1'b1 || tx_wr_data !== bytes[b]) begin
                errors++;
                $display("FAIL lock_data byte=%0d en=%b data=%h expected 1/%h", b, tx_wr_en, tx_wr_data, bytes[b]);
            end
            if (b == 2) req_valid[2] = 1'b0;
            @(negedge clk);
            tx_wr_done = 1'b1;
            @(negedge clk);
            tx_wr_done = 1'b0;
            checks++;
            if (frame_done !== (b == 2)) begin
                errors++;
                $display("FAIL lock_frame_done byte=%0d fd=%b expected %b", b, frame_done, b == 2);
            end
        end
        wait_ready(cyc);
        checks++;
        if (req_ready !== 4'b0001 || grant_id !== 3'd0 || tx_wr_data !== 8'h44) begin
            errors++;
            $display("FAIL lock_next_grant rdy=%b gid=%0d data=%h expected 0001/0/44", req_ready, grant_id, tx_wr_data);
        end
        req_valid = '0;
        @(negedge clk);
        tx_wr_done = 1'b1;
        @(negedge clk);
        tx_wr_done = 1'b0;
        exp_rr = 1;
        wait_idle(ok);
    endtask

    task automatic test_round_robin();
        logic [8:0]  rbuf [NUM_REQ][16];
        int          rhead [NUM_REQ];
        int          rtail [NUM_REQ];
        int          mh [NUM_REQ];
        logic [10:0] expq [$];
        logic [10:0] e;
        int nframes, nf, len, p, g, r2, fdone, budget, delay, wait_cnt, idle_cnt;
        bit in_flight, fin, en_s, ok;
        do_reset();
        for (int round = 0; round < 4; round++) begin
            nframes = 0;
            for (int r = 0; r < NUM_REQ; r++) begin
                rhead[r] = 0; rtail[r] = 0;
                for (int k = 0; k < 16; k++) rbuf[r][k] = '0;
                nf = (round == 0) ? ((r == 0) ? 2 : 1) : $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = (round == 0) ? 1 : $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        rbuf[r][rtail[r]] = {1'(b == len - 1), 8'($urandom)};
                        rtail[r]++;
                    end
                    nframes++;
                end
            end
            // reference: whole frames handed out round-robin starting at the tracked pointer
            p = exp_rr;
            expq.delete();
            for (int r = 0; r < NUM_REQ; r++) mh[r] = 0;
            for (int f = 0; f < nframes; f++) begin
                g = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    r2 = (p + k) % NUM_REQ;
                    if (g < 0 && mh[r2] < rtail[r2]) g = r2;
                end
                fin = 1'b0;
                while (!fin) begin
                    e = {3'(g), rbuf[g][mh[g]][7:0]};
                    expq.push_back(e);
                    fin = rbuf[g][mh[g]][8];
                    mh[g]++;
                end
                p = (g + 1) % NUM_REQ;
            end
            fdone = 0; budget = 0; in_flight = 1'b0; idle_cnt = GAP_CYCLES; delay = 0; wait_cnt = 0;
            while ((expq.size() > 0 || fdone < nframes) && budget < 3000) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    req_valid[r]       = (rhead[r] < rtail[r]);
                    req_data[8*r +: 8] = rbuf[r][rhead[r]][7:0];
                    req_last[r]        = rbuf[r][rhead[r]][8];
                end
                @(negedge clk);
                budget++;
                en_s = tx_wr_en;
                tx_wr_done = 1'b0;
                if (frame_done) fdone++;
                checks++;
                if ($countones(req_ready) > 1) begin
                    errors++;
                    $display("FAIL rr_ready_onehot rdy=%b expected at most one bit", req_ready);
                end
                for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) rhead[r]++;
                if (en_s) begin
                    if (!in_flight) begin
                        in_flight = 1'b1;
                        delay = $urandom_range(0, 10);
                        wait_cnt = 0;
                        checks++;
                        if (idle_cnt < GAP_CYCLES) begin
                            errors++;
                            $display("FAIL rr_gap idle=%0d expected >=%0d", idle_cnt, GAP_CYCLES);
                        end
                    end
                    if (wait_cnt == delay) begin
                        tx_wr_done = 1'b1;
                        in_flight = 1'b0;
                        idle_cnt = 0;
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL rr_extra_byte gid=%0d data=%h expected no byte", grant_id, tx_wr_data);
                        end else begin
                            e = expq.pop_front();
                            if ({grant_id, tx_wr_data} !== e) begin
                                errors++;
                                $display("FAIL rr_byte round=%0d gid=%0d data=%h expected gid=%0d data=%h",
                                         round, grant_id, tx_wr_data, e[10:8], e[7:0]);
                            end
                        end
                        #1;
                        checks++;
                        if (tx_wr_en !== 1'b0) begin
                            errors++;
                            $display("FAIL rr_en_drop en=%b expected 0", tx_wr_en);
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    idle_cnt++;
                end
            end
            tx_wr_done = 1'b0;
            req_valid = '0;
            checks++;
            if (expq.size() != 0 || fdone != nframes) begin
                errors++;
                $display("FAIL rr_round_complete round=%0d left=%0d frames=%0d expected left=0 frames=%0d",
                         round, expq.size(), fdone, nframes);
            end
            exp_rr = p;
            wait_idle(ok);
        end
    endtask

    task automatic test_watchdog();
        int cyc;
        bit ok;
        do_reset();
        req_valid = 4'b0110; req_data = '0; req_data[15:8] = 8'h5C; req_data[23:16] = 8'hC5; req_last = 4'b0110;
        wait_ready(cyc);
        checks++;
        if (req_ready !== 4'b0010 || grant_id !== 3'd1) begin
            errors++;
            $display("FAIL wd_grant rdy=%b gid=%0d expected 0010/1", req_ready, grant_id);
        end
        req_valid[1] = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            checks++;
            if (k < TIMEOUT && (tx_wr_en !== 1'b1 || err_timeout !== 1'b0)) begin
                errors++;
                $display("FAIL wd_wait k=%0d en=%b to=%b expected 1/0", k, tx_wr_en, err_timeout);
            end else if (k == TIMEOUT && (tx_wr_en !== 1'b0 || err_timeout !== 1'b1)) begin
                errors++;
                $display("FAIL wd_expiry en=%b to=%b expected 0/1", tx_wr_en, err_timeout);
            end
        end
        tx_wr_done = 1'b1;
        @(negedge clk);
        tx_wr_done = 1'b0;
        checks++;
        if (frame_done !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_stray_done fd=%b to=%b expected 0/0", frame_done, err_timeout);
        end
        wait_ready(cyc);
        checks++;
        if (req_ready !== 4'b0100 || grant_id !== 3'd2 || tx_wr_data !== 8'hC5) begin
            errors++;
            $display("FAIL wd_next_grant rdy=%b gid=%0d data=%h expected 0100/2/c5", req_ready, grant_id, tx_wr_data);
        end
        req_valid = '0;
        @(negedge clk);
        tx_wr_done = 1'b1;
        @(negedge clk);
        tx_wr_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wd_recover_done fd=%b expected 1", frame_done);
        end
        exp_rr = 3;
        wait_idle(ok);
    endtask

    task automatic test_coincidence();
        int cyc;
        bit ok;
        req_valid = 4'b1000; req_data = '0; req_data[31:24] = 8'hC3; req_last = 4'b1000;
        wait_ready(cyc);
        checks++;
        if (req_ready !== 4'b1000 || grant_id !== 3'd3) begin
            errors++;
            $display("FAIL coin_grant rdy=%b gid=%0d expected 1000/3", req_ready, grant_id);
        end
        req_valid = '0;
        repeat (TIMEOUT - 1) @(negedge clk);
        tx_wr_done = 1'b1;
        #1;
        checks++;
        if (tx_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL coin_en_drop en=%b expected 0", tx_wr_en);
        end
        @(negedge clk);
        tx_wr_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL coin_result fd=%b to=%b expected 1/0", frame_done, err_timeout);
        end
        exp_rr = 0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coin_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        bit ok;
        req_valid = 4'b1000; req_data = '0; req_data[31:24] = 8'h77; req_last = 4'b0000;
        wait_ready(cyc);
        checks++;
        if (req_ready !== 4'b1000 || grant_id !== 3'd3) begin
            errors++;
            $display("FAIL mid_grant rdy=%b gid=%0d expected 1000/3", req_ready, grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        tx_wr_done = 1'b1;
        @(negedge clk);
        tx_wr_done = 1'b0;
        repeat (GAP_CYCLES) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx_wr_en !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL mid_hold busy=%b en=%b rdy=%b expected 1/0/0000", busy, tx_wr_en, req_ready);
        end
        rst = 1'b1;
        req_valid = 4'b1001; req_data[7:0] = 8'h5A; req_data[31:24] = 8'h88; req_last = 4'b0001;
        @(negedge clk);
        checks++;
        if ({busy, tx_wr_en, grant_id, tx_wr_data, req_ready, frame_done, err_timeout} !== '0) begin
            errors++;
            $display("FAIL mid_reset busy=%b en=%b gid=%0d data=%h rdy=%b fd=%b to=%b expected all 0",
                     busy, tx_wr_en, grant_id, tx_wr_data, req_ready, frame_done, err_timeout);
        end
        rst = 1'b0;
        exp_rr = 0;
        wait_ready(cyc);
        checks++;
        if (req_ready !== 4'b0001 || grant_id !== 3'd0 || tx_wr_data !== 8'h5A || cyc != 1) begin
            errors++;
            $display("FAIL mid_fresh_grant rdy=%b gid=%0d data=%h cyc=%0d expected 0001/0/5a/1",
                     req_ready, grant_id, tx_wr_data, cyc);
        end
        req_valid = '0;
        @(negedge clk);
        tx_wr_done = 1'b1;
        @(negedge clk);
        tx_wr_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_fresh_done fd=%b expected 1", frame_done);
        end
        exp_rr = 1;
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_locked_frame();
        test_round_robin();
        test_watchdog();
        test_coincidence();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t expected completion", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
